// File: rtl/puf_cmd_sequencer.sv
// Host command controller: parses framed UART commands, runs one RO-PUF
// evaluation per EVAL frame and queues a status byte plus response bytes.
module puf_cmd_sequencer #(
  parameter int         CHAL_BYTES   = 2,
  parameter int         RESP_BYTES   = 2,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         BYTE_TIMEOUT = 2_700_000,
  parameter int         PUF_TIMEOUT  = 1_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  output logic [8*CHAL_BYTES-1:0] puf_challenge,
  output logic                    puf_start,
  input  logic                    puf_done,
  input  logic [8*RESP_BYTES-1:0] puf_response,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy
);

  localparam int CW   = 8 * CHAL_BYTES;
  localparam int RW   = 8 * RESP_BYTES;
  localparam int TMAX = (BYTE_TIMEOUT > PUF_TIMEOUT) ? BYTE_TIMEOUT : PUF_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BMAX = (CHAL_BYTES > RESP_BYTES) ? CHAL_BYTES : RESP_BYTES;
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [7:0] CMD_EVAL   = 8'h01;
  localparam logic [7:0] CMD_PING   = 8'h02;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_CSUM    = 8'hE1;
  localparam logic [7:0] ST_BAD_CMD = 8'hE2;
  localparam logic [7:0] ST_PUF_TO  = 8'hE3;

  typedef enum logic [2:0] {
    S_SYNC, S_CMD, S_CHAL, S_CSUM, S_EXEC, S_WAIT, S_SEND
  } state_t;

  state_t          state_r, state_n;
  logic [7:0]      cmd_r, cmd_n;
  logic [7:0]      csum_r, csum_n;
  logic [CW-1:0]   shadow_r, shadow_n;
  logic [CW-1:0]   chal_n;
  logic            start_n;
  logic [RW-1:0]   resp_r, resp_n;
  logic [7:0]      txd_n;
  logic            txv_n;
  logic            busy_n;
  logic [TW-1:0]   timer_r, timer_n, timer_inc_s;
  logic [BW-1:0]   bcnt_r, bcnt_n;
  logic [BW-1:0]   left_r, left_n;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_SYNC;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_r         <= 8'h00;
      csum_r        <= 8'h00;
      shadow_r      <= '0;
      puf_challenge <= '0;
      puf_start     <= 1'b0;
      resp_r        <= '0;
      tx_data       <= 8'h00;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      timer_r       <= '0;
      bcnt_r        <= '0;
      left_r        <= '0;
    end else begin
      cmd_r         <= cmd_n;
      csum_r        <= csum_n;
      shadow_r      <= shadow_n;
      puf_challenge <= chal_n;
      puf_start     <= start_n;
      resp_r        <= resp_n;
      tx_data       <= txd_n;
      tx_valid      <= txv_n;
      busy          <= busy_n;
      timer_r       <= timer_n;
      bcnt_r        <= bcnt_n;
      left_r        <= left_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_r;
    cmd_n       = cmd_r;
    csum_n      = csum_r;
    shadow_n    = shadow_r;
    chal_n      = puf_challenge;
    start_n     = 1'b0;
    resp_n      = resp_r;
    txd_n       = tx_data;
    txv_n       = tx_valid;
    timer_n     = timer_r;
    bcnt_n      = bcnt_r;
    left_n      = left_r;
    timer_inc_s = timer_r + TW'(1);
    case (state_r)
      S_SYNC: begin
        if (rx_ready && (rx_data == SYNC_BYTE)) begin
          timer_n = '0;
          state_n = S_CMD;
        end else begin
          state_n = S_SYNC;
        end
      end
      S_CMD: begin
        if (rx_ready) begin
          cmd_n   = rx_data;
          csum_n  = rx_data;
          bcnt_n  = '0;
          timer_n = '0;
          state_n = S_CHAL;
        end else if (timer_inc_s >= TW'(BYTE_TIMEOUT)) begin
          state_n = S_SYNC;
        end else begin
          timer_n = timer_inc_s;
        end
      end
      S_CHAL: begin
        if (rx_ready) begin
          shadow_n = (shadow_r << 8) | CW'(rx_data);
          csum_n   = csum_r ^ rx_data;
          timer_n  = '0;
          if (bcnt_r == BW'(CHAL_BYTES - 1)) begin
            state_n = S_CSUM;
          end else begin
            bcnt_n = bcnt_r + BW'(1);
          end
        end else if (timer_inc_s >= TW'(BYTE_TIMEOUT)) begin
          state_n = S_SYNC;
        end else begin
          timer_n = timer_inc_s;
        end
      end
      S_CSUM: begin
        if (rx_ready) begin
          timer_n = '0;
          left_n  = '0;
          if (rx_data != csum_r) begin
            txd_n   = ST_CSUM;
            txv_n   = 1'b1;
            state_n = S_SEND;
          end else if (cmd_r == CMD_EVAL) begin
            chal_n  = shadow_r;
            start_n = 1'b1;
            state_n = S_EXEC;
          end else if (cmd_r == CMD_PING) begin
            txd_n   = ST_OK;
            txv_n   = 1'b1;
            state_n = S_SEND;
          end else begin
            txd_n   = ST_BAD_CMD;
            txv_n   = 1'b1;
            state_n = S_SEND;
          end
        end else if (timer_inc_s >= TW'(BYTE_TIMEOUT)) begin
          state_n = S_SYNC;
        end else begin
          timer_n = timer_inc_s;
        end
      end
      // Timer counts clocks since the puf_start cycle
      S_EXEC: begin
        timer_n = TW'(1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (puf_done) begin
          resp_n  = puf_response;
          txd_n   = ST_OK;
          txv_n   = 1'b1;
          left_n  = BW'(RESP_BYTES);
          state_n = S_SEND;
        end else if (timer_r >= TW'(PUF_TIMEOUT)) begin
          txd_n   = ST_PUF_TO;
          txv_n   = 1'b1;
          left_n  = '0;
          state_n = S_SEND;
        end else begin
          timer_n = timer_inc_s;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (left_r == '0) begin
            txv_n   = 1'b0;
            state_n = S_SYNC;
          end else begin
            txd_n  = resp_r[RW-1 -: 8];
            resp_n = resp_r << 8;
            left_n = left_r - BW'(1);
          end
        end else begin
          state_n = S_SEND;
        end
      end
      default: begin
        txv_n   = 1'b0;
        state_n = S_SYNC;
      end
    endcase
    busy_n = (state_n != S_SYNC);
  end

endmodule

// File: tb/tb_puf_cmd_sequencer.sv
// Scoreboard bench for puf_cmd_sequencer: a frame-level reference model queues
// expected reply bytes; a monitor pops them on every tx handshake.
module tb_puf_cmd_sequencer;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] puf_challenge;
  logic        puf_start;
  logic        puf_done;
  logic [15:0] puf_response;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_start = 0;
  int          exp_start = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_chal = 16'h0000;
  int          puf_delay = -1;
  logic [15:0] puf_resp = 16'h0000;
  int          ready_mode = 0;

  puf_cmd_sequencer #(
    .CHAL_BYTES  (2),
    .RESP_BYTES  (2),
    .SYNC_BYTE   (8'hA5),
    .BYTE_TIMEOUT(50),
    .PUF_TIMEOUT (100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .puf_challenge(puf_challenge),
    .puf_start    (puf_start),
    .puf_done     (puf_done),
    .puf_response (puf_response),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter side: tx_ready policy
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // PUF core model
  initial begin
    puf_done = 1'b0;
    puf_response = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset_n && puf_start) begin
        n_start++;
        check("puf_challenge_at_start", 32'(puf_challenge), 32'(exp_chal));
        if (puf_delay >= 0) begin
          repeat (puf_delay) @(posedge clk);
          #1;
          puf_done = 1'b1;
          puf_response = puf_resp;
          check("puf_challenge_at_done", 32'(puf_challenge), 32'(exp_chal));
          @(posedge clk);
          #1;
          puf_done = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop on each handshake, stability under back-pressure
  initial begin
    logic       stall;
    logic [7:0] prev;
    logic [7:0] e;
    stall = 1'b0;
    prev = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (stall) begin
          n_vec++;
          if (!tx_valid || tx_data !== prev) begin
            n_err++;
            $display("FAIL tx_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                     tx_valid, tx_data, prev);
          end
        end
        if (tx_valid && tx_ready) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              n_err++;
              $display("FAIL tx_byte: got %0h expected %0h", tx_data, e);
            end
          end
        end
        stall = tx_valid && !tx_ready;
        prev = tx_data;
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  // Reference model: expected reply derived from the frame contents
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] chal,
                           input logic [7:0] csum_err, input int delay,
                           input logic [15:0] resp, input int max_gap);
    logic [7:0] csum;
    csum = cmd ^ chal[15:8] ^ chal[7:0] ^ csum_err;
    if (csum_err != 8'h00) begin
      exp_q.push_back(8'hE1);
    end else if (cmd == 8'h01) begin
      exp_start++;
      exp_chal = chal;
      if (delay < 0) begin
        exp_q.push_back(8'hE3);
      end else begin
        exp_q.push_back(8'h00);
        exp_q.push_back(resp[15:8]);
        exp_q.push_back(resp[7:0]);
      end
    end else if (cmd == 8'h02) begin
      exp_q.push_back(8'h00);
    end else begin
      exp_q.push_back(8'hE2);
    end
    puf_delay = delay;
    puf_resp = resp;
    send_byte(8'hA5);
    repeat ($urandom_range(0, max_gap)) @(posedge clk);
    send_byte(cmd);
    repeat ($urandom_range(0, max_gap)) @(posedge clk);
    send_byte(chal[15:8]);
    repeat ($urandom_range(0, max_gap)) @(posedge clk);
    send_byte(chal[7:0]);
    repeat ($urandom_range(0, max_gap)) @(posedge clk);
    send_byte(csum);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 3000) begin
      n_err++;
      $display("FAIL reply_timeout: got %0d bytes pending busy=%0b expected 0 pending busy=0",
               exp_q.size(), busy);
      exp_q.delete();
    end
    check("puf_start_count", 32'(n_start), 32'(exp_start));
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    rx_ready = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_puf_start", 32'(puf_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_puf_challenge", 32'(puf_challenge), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // PING: reply on the cycle after the checksum byte
    run_frame(8'h02, 16'h0000, 8'h00, -1, 16'h0000, 0);
    @(negedge clk);
    check("ping_latency_tx_valid", 32'(tx_valid), 32'd1);
    wait_idle();
    check("ping_busy_after", 32'(busy), 32'd0);

    // EVAL 1234 -> BEEF after 50 clk
    run_frame(8'h01, 16'h1234, 8'h00, 50, 16'hBEEF, 0);
    @(negedge clk);
    check("eval_latency_puf_start", 32'(puf_start), 32'd1);
    wait_idle();

    // Checksum error and unknown command
    run_frame(8'h01, 16'h1234, 8'h27, 50, 16'hBEEF, 0);
    wait_idle();
    run_frame(8'h07, 16'h0000, 8'h00, -1, 16'h0000, 0);
    wait_idle();

    // PUF timeout, then a late puf_done must be ignored
    run_frame(8'h01, 16'hCAFE, 8'h00, -1, 16'h0000, 0);
    k = 0;
    while (!tx_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k - 1 < 100 || k - 1 > 101) begin
      n_err++;
      $display("FAIL puf_timeout_latency: got %0d expected 100..101", k - 1);
    end
    wait_idle();
    @(posedge clk);
    #1;
    puf_done = 1'b1;
    puf_response = 16'h5555;
    @(posedge clk);
    #1;
    puf_done = 1'b0;
    repeat (20) @(negedge clk);
    check("late_done_busy", 32'(busy), 32'd0);

    // Frame recovery after inter-byte timeout
    send_byte(8'h3C);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (60) @(negedge clk);
    check("byte_timeout_busy", 32'(busy), 32'd0);
    run_frame(8'h02, 16'h0000, 8'h00, -1, 16'h0000, 0);
    wait_idle();

    // Back-pressure with bytes arriving while busy
    ready_mode = 2;
    run_frame(8'h01, 16'h1234, 8'h00, 50, 16'hBEEF, 0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    k = 0;
    while (!tx_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    repeat (10) @(negedge clk);
    ready_mode = 0;
    wait_idle();

    // Reset in the middle of a reply
    ready_mode = 2;
    run_frame(8'h01, 16'h0F0F, 8'h00, 10, 16'h1357, 0);
    k = 0;
    while (!tx_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("midsend_reset_tx_valid", 32'(tx_valid), 32'd0);
    check("midsend_reset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    ready_mode = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_frame(8'h02, 16'h0000, 8'h00, -1, 16'h0000, 0);
    wait_idle();

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  cmd;
      logic [7:0]  err;
      logic [15:0] chal;
      logic [15:0] resp;
      int          sel;
      int          dly;
      sel = $urandom_range(0, 9);
      if (sel < 4) cmd = 8'h01;
      else if (sel < 7) cmd = 8'h02;
      else cmd = 8'($urandom_range(0, 255));
      err  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      dly  = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(2, 90);
      chal = 16'($urandom());
      resp = 16'($urandom());
      ready_mode = $urandom_range(0, 1);
      run_frame(cmd, chal, err, dly, resp, 3);
      wait_idle();
    end
    ready_mode = 0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
